mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the per-core cache blocks and upstream of the shared RAM.
- Arbitrates instruction-fetch and data read/write requests from NCPUS cores onto a single RAM port.
- Returns per-port wait and load data to the caches.
- Policy: round-robin between cores; within a core, data beats instruction.

Parameters:
NCPUS, 2, number of cores served (1..4)
AW, 32, address/data word width (word_t)

Ports:
CLK  in  1  system clock, all state updates on posedge
RST  in  1  synchronous reset, active-high
iREN  in  NCPUS  per-core instruction read request
iaddr  in  NCPUS x AW  per-core instruction address
iwait  out  NCPUS  per-core instruction wait (0 = iload valid this cycle)
iload  out  NCPUS x AW  per-core instruction data
dREN  in  NCPUS  per-core data read request
dWEN  in  NCPUS  per-core data write request
daddr  in  NCPUS x AW  per-core data address
dstore  in  NCPUS x AW  per-core write data
dwait  out  NCPUS  per-core data wait (0 = access completes this cycle)
dload  out  NCPUS x AW  per-core read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  AW  RAM address
ramstore  out  AW  RAM write data
ramload  in  AW  RAM read data
ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset (RST=1 at posedge): state=IDLE, rr_ptr=0, grant regs cleared. Outputs during and after reset: all iwait/dwait=1, all iload/dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- wait outputs are 1 in every cycle except the completion cycle of the granted port. This holds for non-requesting ports too.
- Request classes per core: D = dREN|dWEN; I = iREN. dREN and dWEN both high is illegal; treat it as a write.
- FSM, IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise scan cores starting at rr_ptr, wrapping modulo NCPUS; the first core with D or I pending wins.
  - Within the winning core, D beats I.
  - Register gcore and gtype; go to ACCESS next cycle.
- FSM, ACCESS:
  - Drive ramREN/ramWEN/ramaddr/ramstore from the granted core's live inputs. The requester must hold its inputs stable while its wait=1.
  - ramstate FREE or BUSY: stay.
  - ramstate ERROR: stay and keep the strobe asserted (retry).
  - ramstate ACCESS: same cycle, drop the granted port's wait to 0 and drive its load = ramload combinationally. Set rr_ptr=(gcore+1) mod NCPUS and go to IDLE.
- Latency: request first seen in IDLE at cycle N; earliest completion is cycle N+1. A zero-wait RAM gives one access per 2 cycles.
- Back-to-back: a port still asserting after completion re-arbitrates in IDLE. Round-robin prevents starvation: the worst-case wait for any core is NCPUS-1 other accesses, plus its own I/D ordering.
- A grant is never pre-empted. A newly raised higher-priority request waits for the next IDLE.
- Requests dropped while in ACCESS are illegal (undefined RAM traffic); only RST aborts.
- RST mid-access: on the next posedge, state=IDLE and strobes drop.
- Non-granted load outputs = 0. Addresses pass through unmodified (byte address, word aligned).

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined: adds output ports grant_cnt (NCPUS x 32) and stall_cnt (NCPUS x 32).
  - grant_cnt[c] increments on each completion for core c.
  - stall_cnt[c] increments every cycle core c has D or I asserted and is not completing.
  - Both reset to 0, wrap at 2^32, and freeze while RST=1.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: RST=1 for 2 cycles with all requests high -> all waits=1, ramREN=ramWEN=0. First grant goes to core0 D after RST falls.
- Single read: core0 iREN, iaddr=0x40, RAM ACCESS on 2nd cycle with ramload=0x8C010004 -> ramaddr=0x40, iwait[0]=0 for exactly one cycle, iload[0]=0x8C010004.
- Intra-core priority: core1 dWEN daddr=0x100 dstore=0xDEADBEEF plus iREN together -> write issued first (ramWEN=1, ramstore=0xDEADBEEF), instruction fetch served next.
- Round-robin: both cores hold dREN continuously, RAM always ACCESS -> completions alternate 0,1,0,1; neither port waits more than 3 cycles.
- RAM latency and error: ramstate BUSY 3 cycles, ERROR 1, then ACCESS -> strobe held throughout, dwait=0 only on the ACCESS cycle.
- Reset mid-access: RST asserted during ACCESS -> next cycle IDLE, strobes 0, rr_ptr=0. With PERF_EN, counters also read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of per-core I/D requests onto one RAM port (MEM_ARBITER_PERF_EN adds grant/stall counters)
module mem_arbiter #(
  parameter int NCPUS = 2,
  parameter int AW    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCPUS-1:0]    iREN,
  input  logic [NCPUS*AW-1:0] iaddr,
  output logic [NCPUS-1:0]    iwait,
  output logic [NCPUS*AW-1:0] iload,
  input  logic [NCPUS-1:0]    dREN,
  input  logic [NCPUS-1:0]    dWEN,
  input  logic [NCPUS*AW-1:0] daddr,
  input  logic [NCPUS*AW-1:0] dstore,
  output logic [NCPUS-1:0]    dwait,
  output logic [NCPUS*AW-1:0] dload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [AW-1:0]       ramaddr,
  output logic [AW-1:0]       ramstore,
  input  logic [AW-1:0]       ramload,
  input  logic [1:0]          ramstate
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [NCPUS*32-1:0] grant_cnt,
  output logic [NCPUS*32-1:0] stall_cnt
`endif
);
  localparam int GW = NCPUS > 1 ? $clog2(NCPUS) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d, gcore_q, gcore_d, win, idx;
  logic gtype_q, gtype_d, found;
  logic [NCPUS-1:0] req_d, req, done;
  logic [AW-1:0] iaddr_a [NCPUS];
  logic [AW-1:0] daddr_a [NCPUS];
  logic [AW-1:0] dstore_a [NCPUS];
  logic [AW-1:0] iload_a [NCPUS];
  logic [AW-1:0] dload_a [NCPUS];
  assign req_d = dREN | dWEN;
  assign req   = req_d | iREN;
  assign iwait = ~(done & {NCPUS{~gtype_q}});
  assign dwait = ~(done & {NCPUS{gtype_q}});
  genvar c;
  for (c = 0; c < NCPUS; c++) begin : g_port
    assign iaddr_a[c]          = iaddr[c*AW +: AW];
    assign daddr_a[c]          = daddr[c*AW +: AW];
    assign dstore_a[c]         = dstore[c*AW +: AW];
    assign iload[c*AW +: AW]   = iload_a[c];
    assign dload[c*AW +: AW]   = dload_a[c];
  end
  // scan from rr_ptr downward in priority so the first requester in ring order wins
  always_comb begin
    win   = rr_ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = NCPUS - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr_q) + k) % NCPUS);
      if (req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
  // next state and RAM/port drive; RAM side is quiet whenever RST is high
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gcore_d  = gcore_q;
    gtype_d  = gtype_q;
    done     = '0;
    for (int k = 0; k < NCPUS; k++) begin
      iload_a[k] = '0;
      dload_a[k] = '0;
    end
    ramWEN   = 1'b0;
    ramREN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == IDLE) begin
      state_d = found ? ACCESS : IDLE;
      gcore_d = found ? win : gcore_q;
      gtype_d = found ? req_d[win] : gtype_q;
    end else if (!RST) begin
      ramWEN   = gtype_q & dWEN[gcore_q];
      ramREN   = ~ramWEN;
      ramaddr  = gtype_q ? daddr_a[gcore_q] : iaddr_a[gcore_q];
      ramstore = ramWEN ? dstore_a[gcore_q] : '0;
      if (ramstate == 2'd2) begin
        done[gcore_q]    = 1'b1;
        iload_a[gcore_q] = gtype_q ? '0 : ramload;
        dload_a[gcore_q] = gtype_q ? ramload : '0;
        rr_ptr_d         = GW'((int'(gcore_q) + 1) % NCPUS);
        state_d          = IDLE;
      end
    end
  end
  // state, round-robin pointer and grant registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gcore_q  <= '0;
      gtype_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gcore_q  <= gcore_d;
      gtype_q  <= gtype_d;
    end
  end
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] gcnt_q [NCPUS];
  logic [31:0] gcnt_d [NCPUS];
  logic [31:0] scnt_q [NCPUS];
  logic [31:0] scnt_d [NCPUS];
  // completions per core, and cycles a core is requesting without completing
  always_comb begin
    for (int k = 0; k < NCPUS; k++) begin
      gcnt_d[k] = gcnt_q[k] + 32'(done[k]);
      scnt_d[k] = scnt_q[k] + 32'(req[k] & ~done[k]);
    end
  end
  // counters clear and hold at zero while RST is high
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NCPUS; k++) begin
      gcnt_q[k] <= RST ? '0 : gcnt_d[k];
      scnt_q[k] <= RST ? '0 : scnt_d[k];
    end
  end
  for (c = 0; c < NCPUS; c++) begin : g_perf
    assign grant_cnt[c*32 +: 32] = gcnt_q[c];
    assign stall_cnt[c*32 +: 32] = scnt_q[c];
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int N = 2;
  localparam logic [31:0] K = 32'h5A5A_0000;
  typedef struct packed {
    int          core;
    logic        isd;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [N-1:0] iREN = '0, dREN = '0, dWEN = '0;
  logic [N*32-1:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [N-1:0] iwait, dwait;
  logic [N*32-1:0] iload, dload;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate = 2'd0;
  logic use_fixed = 1'b0;
  logic [31:0] fixed_val = '0;
  logic hold = 1'b0;
  logic s_ren, s_wen;
  logic [N-1:0] s_iwait, s_dwait;
  exp_t sb [$];
  int errors = 0;
  int checks = 0;
`ifdef MEM_ARBITER_PERF_EN
  logic [N*32-1:0] grant_cnt, stall_cnt;
`endif

  assign ramload = use_fixed ? fixed_val : (ramaddr ^ K);

  mem_arbiter #(.NCPUS(N), .AW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARBITER_PERF_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int core, input logic isd, input logic wen,
                      input logic [31:0] addr, input logic [31:0] store, input logic [31:0] load);
    exp_t e;
    e = '{core, isd, wen, addr, store, load};
    sb.push_back(e);
  endtask

  // one cycle: sample outputs 1ns after the negedge, score completions, then advance to next negedge
  task automatic cyc();
    logic [N-1:0] di, dd;
    logic nz;
    exp_t e;
    int c;
    #1;
    di = ~iwait;
    dd = ~dwait;
    s_ren = ramREN;
    s_wen = ramWEN;
    s_iwait = iwait;
    s_dwait = dwait;
    nz = 1'b0;
    for (int k = 0; k < N; k++)
      if ((iwait[k] && iload[k*32 +: 32] != 0) || (dwait[k] && dload[k*32 +: 32] != 0)) nz = 1'b1;
    chk("nongrant_load_zero", 32'(nz), 32'd0);
    if ((di | dd) != 0) begin
      chk("single_completion", $countones({di, dd}), 32'd1);
      chk("completion_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        c = (di[1] | dd[1]) ? 1 : 0;
        chk("grant_core", c, e.core);
        chk("grant_type", 32'(|dd), 32'(e.isd));
        chk("ram_addr", ramaddr, e.addr);
        chk("ram_wen", 32'(ramWEN), 32'(e.wen));
        chk("ram_ren", 32'(ramREN), 32'(!e.wen));
        if (e.wen) chk("ram_store", ramstore, e.store);
        chk("load_data", (|dd) ? dload[c*32 +: 32] : iload[c*32 +: 32], e.load);
      end
    end
    @(negedge CLK);
    if (!hold) begin
      iREN &= ~di;
      dREN &= ~dd;
      dWEN &= ~dd;
    end
  endtask

  task automatic run(input int max, output int n);
    n = 0;
    while (sb.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk("drain_in_budget", sb.size(), 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
    // reset with every request high
    iREN = '1; dREN = '1;
    iaddr = {32'h34, 32'h30};
    daddr = {32'h20, 32'h10};
    ramstate = 2'd2;
    @(negedge CLK);
    repeat (2) begin
      cyc();
      chk("rst_ren", 32'(s_ren), 32'd0);
      chk("rst_wen", 32'(s_wen), 32'd0);
      chk("rst_iwait", 32'(s_iwait), 32'(2'b11));
      chk("rst_dwait", 32'(s_dwait), 32'(2'b11));
    end
    RST = 1'b0;
    push(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h10 ^ K);
    run(6, n);
    chk("rst_first_grant_latency", n, 32'd2);
    iREN = '0; dREN = '0;
    repeat (2) cyc();
    // single instruction read, RAM completes on second cycle
    iREN[0] = 1'b1;
    iaddr[31:0] = 32'h40;
    use_fixed = 1'b1;
    fixed_val = 32'h8C01_0004;
    ramstate = 2'd0;
    push(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C01_0004);
    cyc();
    ramstate = 2'd2;
    run(5, n);
    chk("single_read_latency", n, 32'd1);
    use_fixed = 1'b0;
    repeat (2) cyc();
    // data write beats instruction fetch within one core
    dWEN[1] = 1'b1;
    daddr[63:32] = 32'h100;
    dstore[63:32] = 32'hDEAD_BEEF;
    iREN[1] = 1'b1;
    iaddr[63:32] = 32'h200;
    push(1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h100 ^ K);
    push(1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h200 ^ K);
    run(10, n);
    chk("intra_core_cycles", n, 32'd4);
    repeat (2) cyc();
    // round robin with both cores holding data reads
    hold = 1'b1;
    dREN = '1;
    daddr = {32'h2000, 32'h1000};
    push(0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h1000 ^ K);
    push(1, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h2000 ^ K);
    push(0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h1000 ^ K);
    push(1, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h2000 ^ K);
    run(20, n);
    chk("rr_cycles", n, 32'd8);
    dREN = '0;
    hold = 1'b0;
    repeat (2) cyc();
    // BUSY x3, ERROR x1, then ACCESS: strobe held, wait drops only on ACCESS
    dREN[0] = 1'b1;
    daddr[31:0] = 32'h300;
    push(0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h300 ^ K);
    for (int i = 0; i < 6; i++) begin
      ramstate = seq[i];
      cyc();
      chk("lat_ren", 32'(s_ren), 32'(i >= 1));
      chk("lat_dwait0", 32'(s_dwait[0]), 32'(i != 5));
    end
    chk("lat_completed", sb.size(), 32'd0);
    repeat (2) cyc();
    // reset during an access aborts it and clears the round-robin pointer
    iREN[1] = 1'b1;
    iaddr[63:32] = 32'h400;
    ramstate = 2'd1;
    cyc();
    cyc();
    chk("mid_access_ren", 32'(s_ren), 32'd1);
    RST = 1'b1;
    cyc();
    chk("mid_rst_ren", 32'(s_ren), 32'd0);
    chk("mid_rst_iwait", 32'(s_iwait), 32'(2'b11));
    RST = 1'b0;
    iREN = '0;
    cyc();
    chk("post_rst_ren", 32'(s_ren), 32'd0);
    chk("post_rst_dwait", 32'(s_dwait), 32'(2'b11));
`ifdef MEM_ARBITER_PERF_EN
    chk("post_rst_grant_cnt", 32'(grant_cnt != 0), 32'd0);
    chk("post_rst_stall_cnt", 32'(stall_cnt != 0), 32'd0);
`endif
    ramstate = 2'd2;
    dREN = '1;
    daddr = {32'h600, 32'h500};
    push(0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h500 ^ K);
    push(1, 1'b1, 1'b0, 32'h600, 32'h0, 32'h600 ^ K);
    run(10, n);
    chk("post_rst_rr_cycles", n, 32'd4);
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
